// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite slave bridging to a single-port 64-bit SRAM macro
module ahb_sram_slave #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          MEM_AW    = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [63:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic              hmastlock,
    input  logic [63:0]       hwdata,
    input  logic              hready_in,
    output logic              hready,
    output logic              hresp,
    output logic [63:0]       hrdata,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [7:0]        sram_wmask,
    output logic [63:0]       sram_wdata,
    input  logic [63:0]       sram_rdata
);

    localparam int WIN_LSB = MEM_AW + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD1,
        S_RD2,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [WIN_LSB-1:0]  addr_q;
    logic                write_q;
    logic [2:0]          size_q;
    logic [63:0]         rdata_q;
    logic                accept;
    logic                misaligned;
    logic                out_of_window;
    logic                bad_xfer;
    logic [7:0]          lane_mask;

    // Burst type, protection and lock carry no meaning for a plain SRAM.
    logic unused_ok;
    assign unused_ok = &{1'b0, hburst, hprot, hmastlock};

    // Only the waitless states can take a new address phase; RD1/ERR1 stall the bus.
    assign hready = !(state == S_RD1 || state == S_ERR1);
    assign hresp  = (state == S_ERR1 || state == S_ERR2);
    assign accept = hsel && hready_in && htrans[1] && hready;

    // Classify the address phase: bad size, misaligned, or outside the SRAM window.
    always_comb begin
        misaligned = 1'b0;
        case (hsize)
            3'd0:    misaligned = 1'b0;
            3'd1:    misaligned = haddr[0];
            3'd2:    misaligned = |haddr[1:0];
            3'd3:    misaligned = |haddr[2:0];
            default: misaligned = 1'b1;
        endcase
        out_of_window = (haddr[63:WIN_LSB] != BASE_ADDR[63:WIN_LSB]);
        bad_xfer      = misaligned || out_of_window;
    end

    // Next-state: a fresh acceptance always wins, otherwise wait states advance and all else idles.
    always_comb begin
        state_nx = S_IDLE;
        if (accept) begin
            if (bad_xfer)     state_nx = S_ERR1;
            else if (hwrite)  state_nx = S_WR;
            else              state_nx = S_RD1;
        end else begin
            case (state)
                S_RD1:   state_nx = S_RD2;
                S_ERR1:  state_nx = S_ERR2;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // State register, address-phase capture and read-data hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            rdata_q <= 64'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= haddr[WIN_LSB-1:0];
                write_q <= hwrite;
                size_q  <= hsize;
            end
            if (state == S_RD2) begin
                rdata_q <= sram_rdata;
            end
        end
    end

    // Little-endian lane enables before shifting to the byte offset.
    always_comb begin
        case (size_q)
            3'd0:    lane_mask = 8'h01;
            3'd1:    lane_mask = 8'h03;
            3'd2:    lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
    end

    // SRAM is only touched in the data phase; reset suppresses any access on that edge.
    always_comb begin
        sram_ce    = !rst && ((state == S_WR && write_q) || (state == S_RD1 && !write_q));
        sram_we    = !rst && (state == S_WR);
        sram_wmask = (!rst && state == S_WR) ? (lane_mask << addr_q[2:0]) : 8'h00;
        sram_addr  = addr_q[WIN_LSB-1:3];
        sram_wdata = hwdata;
        hrdata     = (state == S_RD2) ? sram_rdata : rdata_q;
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - randomized self-checking bench for ahb_sram_slave
module tb_ahb_sram_slave;

    localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;
    localparam int          MEM_AW = 14;
    localparam logic [63:0] WIN    = 64'd8 << MEM_AW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hsel = 1'b0;
    logic [63:0]       haddr = '0;
    logic [1:0]        htrans = 2'b00;
    logic              hwrite = 1'b0;
    logic [2:0]        hsize = 3'd0;
    logic [2:0]        hburst = 3'd0;
    logic [3:0]        hprot = 4'd0;
    logic              hmastlock = 1'b0;
    logic [63:0]       hwdata = '0;
    logic              hready_in;
    logic              hready_en = 1'b1;
    logic              hready;
    logic              hresp;
    logic [63:0]       hrdata;
    logic              sram_ce;
    logic              sram_we;
    logic [MEM_AW-1:0] sram_addr;
    logic [7:0]        sram_wmask;
    logic [63:0]       sram_wdata;
    logic [63:0]       sram_rdata = '0;

    always #5 clk = ~clk;

    assign hready_in = hready & hready_en;

    ahb_sram_slave #(.BASE_ADDR(BASE), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hmastlock(hmastlock), .hwdata(hwdata), .hready_in(hready_in),
        .hready(hready), .hresp(hresp), .hrdata(hrdata), .sram_ce(sram_ce),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wmask(sram_wmask),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Behavioural SRAM macro the slave talks to.
    bit [63:0] sram_mem [0:(1<<MEM_AW)-1];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 8; b++)
                    if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model: byte-addressed memory plus the transfer in its data phase.
    bit [7:0]    ref_mem [bit [63:0]];
    logic [63:0] last_hrdata = '0;

    typedef struct {
        bit          valid;
        bit          err;
        bit          wr;
        logic [63:0] addr;
        logic [2:0]  sz;
        logic [63:0] wd;
    } xfer_t;
    xfer_t pend;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_err(input logic [63:0] a, input logic [2:0] sz);
        if (sz > 3) return 1'b1;
        if ((a % (64'd1 << sz)) != 0) return 1'b1;
        if (a < BASE || a >= BASE + WIN) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] ref_word(input logic [63:0] a);
        logic [63:0] w;
        logic [63:0] k;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            k = (a & ~64'h7) + 64'(i);
            w[8*i +: 8] = ref_mem.exists(k) ? ref_mem[k] : 8'h00;
        end
        return w;
    endfunction

    // One bus step, entered at a falling edge: finish the current data phase, then drive a new address phase.
    task automatic step(input logic [1:0] tr, input logic [63:0] a, input logic w,
                        input logic [2:0] sz, input logic sel, input logic [63:0] wd);
        int guard;
        int exp_waits;
        int nb;
        int mask;
        hwdata = pend.wd;
        #1;
        guard = 0;
        while (hready !== 1'b1 && guard < 4) begin
            check_eq("wait_resp", hresp, pend.err);
            check_eq("wait_ce", sram_ce, pend.valid && !pend.err && !pend.wr);
            if (pend.valid && !pend.err && !pend.wr) begin
                check_eq("rd1_addr", sram_addr, (pend.addr - BASE) >> 3);
                check_eq("rd1_we", sram_we, 0);
                check_eq("rd1_hold", hrdata, last_hrdata);
            end
            @(negedge clk);
            #1;
            guard++;
        end
        exp_waits = (pend.valid && (pend.err || !pend.wr)) ? 1 : 0;
        check_eq("waits", guard, exp_waits);
        if (!pend.valid) begin
            check_eq("idle_resp", hresp, 0);
            check_eq("idle_ce", sram_ce, 0);
            check_eq("idle_hold", hrdata, last_hrdata);
        end else if (pend.err) begin
            check_eq("err2_resp", hresp, 1);
            check_eq("err2_ce", sram_ce, 0);
        end else if (pend.wr) begin
            nb = 1 << pend.sz;
            mask = ((1 << nb) - 1) << (pend.addr % 8);
            check_eq("wr_resp", hresp, 0);
            check_eq("wr_ce", sram_ce, 1);
            check_eq("wr_we", sram_we, 1);
            check_eq("wr_addr", sram_addr, (pend.addr - BASE) >> 3);
            check_eq("wr_mask", sram_wmask, 64'(mask & 255));
            check_eq("wr_data", sram_wdata, pend.wd);
            for (int i = 0; i < nb; i++)
                ref_mem[pend.addr + 64'(i)] = pend.wd[8*((pend.addr + 64'(i)) % 8) +: 8];
        end else begin
            check_eq("rd_resp", hresp, 0);
            check_eq("rd2_ce", sram_ce, 0);
            check_eq("rd_data", hrdata, ref_word(pend.addr));
            last_hrdata = ref_word(pend.addr);
        end
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        hsel   = sel;
        pend.valid = sel && tr[1];
        pend.err   = exp_err(a, sz);
        pend.wr    = w;
        pend.addr  = a;
        pend.sz    = sz;
        pend.wd    = wd;
        @(negedge clk);
    endtask

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

    initial begin
        logic [63:0] a;
        logic [2:0]  sz;
        int          k;
        int          off;
        pend.valid = 1'b0;
        pend.err = 1'b0;
        pend.wr = 1'b0;
        pend.addr = '0;
        pend.sz = '0;
        pend.wd = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_hready", hready, 1);
        check_eq("rst_hresp", hresp, 0);
        check_eq("rst_hrdata", hrdata, 0);
        check_eq("rst_ce", sram_ce, 0);
        check_eq("rst_we", sram_we, 0);
        check_eq("rst_wmask", sram_wmask, 0);
        @(negedge clk);
        rst = 1'b0;

        // Dword write then read of the same address, first transfer right after reset
        step(NSEQ, 64'h8000_0010, 1, 3'd3, 1, 64'h1122_3344_5566_7788);
        step(NSEQ, 64'h8000_0010, 0, 3'd3, 1, 64'h0);
        // Byte write into lane 3, then dword read
        step(NSEQ, 64'h8000_0013, 1, 3'd0, 1, 64'hA5A5_A5A5_A5A5_A5A5);
        step(NSEQ, 64'h8000_0010, 0, 3'd3, 1, 64'h0);
        // Error cases chained back to back, plus window edges
        step(NSEQ, 64'h8002_0000, 1, 3'd3, 1, 64'hDEAD);
        step(NSEQ, 64'h8000_0001, 0, 3'd1, 1, 64'h0);
        step(NSEQ, 64'h8000_0000, 0, 3'd4, 1, 64'h0);
        step(NSEQ, 64'h7FFF_FFF8, 0, 3'd3, 1, 64'h0);
        step(NSEQ, 64'h8001_FFF8, 1, 3'd3, 1, 64'hCAFE_F00D_1234_5678);
        step(NSEQ, 64'h8001_FFF8, 0, 3'd3, 1, 64'h0);
        step(IDLE, 64'h0, 0, 3'd0, 1, 64'h0);
        // INCR4 write burst with a BUSY inserted, then a read with no bubble
        step(NSEQ, 64'h8000_0000, 1, 3'd3, 1, 64'h0101_0101_0101_0101);
        step(SEQ,  64'h8000_0008, 1, 3'd3, 1, 64'h0202_0202_0202_0202);
        step(BUSY, 64'h8000_0010, 1, 3'd3, 1, 64'h0);
        step(SEQ,  64'h8000_0010, 1, 3'd3, 1, 64'h0303_0303_0303_0303);
        step(SEQ,  64'h8000_0018, 1, 3'd3, 1, 64'h0404_0404_0404_0404);
        step(NSEQ, 64'h8000_0008, 0, 3'd3, 1, 64'h0);
        step(IDLE, 64'h0, 0, 3'd0, 1, 64'h0);

        // Bus hready low: NONSEQ must not be taken
        #1;
        hready_en = 1'b0;
        htrans = NSEQ; hsel = 1'b1; hwrite = 1'b1; haddr = 64'h8000_0020; hsize = 3'd3;
        @(negedge clk);
        #1;
        check_eq("hrin_ce", sram_ce, 0);
        check_eq("hrin_hready", hready, 1);
        check_eq("hrin_hresp", hresp, 0);
        htrans = IDLE;
        hready_en = 1'b1;

        // Reset while in RD1 abandons the read
        step(NSEQ, 64'h8000_0018, 0, 3'd3, 1, 64'h0);
        #1;
        htrans = IDLE;
        rst = 1'b1;
        #1;
        check_eq("rstrd_ce_now", sram_ce, 0);
        @(negedge clk);
        #1;
        check_eq("rstrd_hready", hready, 1);
        check_eq("rstrd_hrdata", hrdata, 0);
        check_eq("rstrd_ce", sram_ce, 0);
        rst = 1'b0;
        pend.valid = 1'b0;
        pend.wd = '0;
        last_hrdata = '0;
        step(NSEQ, 64'h8000_0010, 0, 3'd3, 1, 64'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            sz = 3'($urandom_range(0, 3));
            off = $urandom_range(0, 7);
            a = BASE + 64'($urandom_range(0, 15) * 8);
            case ($urandom_range(0, 19))
                0: a = ($urandom_range(0, 1) != 0) ? BASE + WIN + 64'($urandom_range(0, 3) * 8) : BASE - 8;
                1: sz = 3'($urandom_range(4, 7));
                2: a = a + 64'(off);
                default: a = a + 64'(off & ~((1 << sz) - 1));
            endcase
            step(k < 1 ? IDLE : k < 2 ? BUSY : k < 6 ? NSEQ : SEQ, a, 1'($urandom_range(0, 1)),
                 sz, $urandom_range(0, 9) != 0, {$urandom, $urandom});
        end
        step(IDLE, 64'h0, 0, 3'd0, 1, 64'h0);
        step(IDLE, 64'h0, 0, 3'd0, 1, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
